// File: rtl/intc_pkg.sv
// Shared definitions for the multi-source interrupt controller.
// Register map indices, FSM state encoding and CTRL bit positions.
package intc_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_ID   = 2'd3;

  localparam int CTRL_GIE_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERV
  } state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder for pending interrupt sources.
// Purely combinational: returns the ID of the lowest set bit and a valid flag.
module intc_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 5
) (
  input  logic [NUM_IRQ-1:0] vec,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  always_comb begin
    id    = '0;
    valid = |vec;
    // Scan downward so the lowest set index is written last.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Prioritised multi-source interrupt controller on the I/O bus.
// Define INTC_SYNC_EN to add a 2-flop synchroniser on every irq_in bit.
module int_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cs,
  input  logic               rd,
  input  logic               wr,
  input  logic [1:0]         addr,
  input  logic [DATA_W-1:0]  d_in,
  output logic [DATA_W-1:0]  d_out,
  output logic               intr,
  input  logic               int_ack,
  output logic [ID_W-1:0]    vec_id,
  output logic               in_service
);

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] edges;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] pend_n;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] act;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] ack_clr;
  logic               gie;
  state_t             state;
  logic [ID_W-1:0]    sel_id;
  logic               sel_vld;
  logic               wr_pend;
  logic               wr_mask;
  logic               wr_ctrl;
  logic               eoi;
  logic               ack_go;
  logic               unused_bits;

`ifdef INTC_SYNC_EN
  logic [NUM_IRQ-1:0] sync1;
  logic [NUM_IRQ-1:0] sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = irq_in;
`endif

  assign edges   = irq_s & ~irq_prev;
  assign act     = pend & mask;
  assign wr_pend = cs && wr && addr == REG_PEND;
  assign wr_mask = cs && wr && addr == REG_MASK;
  assign wr_ctrl = cs && wr && addr == REG_CTRL;
  assign eoi     = cs && wr && addr == REG_ID;
  assign ack_go  = state == REQ && int_ack && sel_vld;

  assign unused_bits = ^d_in;

  intc_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_enc (
    .vec   (act),
    .id    (sel_id),
    .valid (sel_vld)
  );

  // New edges are OR-ed in last so they survive a same-cycle clear.
  assign w1c     = wr_pend ? d_in[NUM_IRQ-1:0] : '0;
  assign ack_clr = ack_go ? (NUM_IRQ'(1) << sel_id) : '0;
  assign pend_n  = (pend & ~w1c & ~ack_clr) | edges;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev <= '0;
      pend     <= '0;
      mask     <= '0;
      gie      <= 1'b0;
    end else begin
      irq_prev <= irq_s;
      pend     <= pend_n;
      if (wr_mask) mask <= d_in[NUM_IRQ-1:0];
      if (wr_ctrl) gie <= d_in[CTRL_GIE_BIT];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      intr       <= 1'b0;
      vec_id     <= '0;
      in_service <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          intr <= 1'b0;
          if (gie && |act) state <= REQ;
        end
        REQ: begin
          if (ack_go) begin
            state      <= SERV;
            intr       <= 1'b0;
            in_service <= 1'b1;
            vec_id     <= sel_id;
          end else if (!sel_vld || !gie) begin
            state <= IDLE;
            intr  <= 1'b0;
          end else begin
            intr <= 1'b1;
          end
        end
        SERV: begin
          intr <= 1'b0;
          if (eoi) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    d_out = '0;
    if (cs && rd) begin
      unique case (addr)
        REG_PEND: d_out = DATA_W'(pend);
        REG_MASK: d_out = DATA_W'(mask);
        REG_CTRL: d_out[CTRL_GIE_BIT] = gie;
        REG_ID: begin
          d_out[ID_W-1:0]   = vec_id;
          d_out[DATA_W-1]   = in_service;
        end
        default: d_out = '0;
      endcase
    end
  end

endmodule
